// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexes one hex-to-7-segment decoder across an
// 8-digit common-anode display. Holds an 8 x 4-bit digit register file,
// scans one digit per slot of REFRESH_DIV cycles and blanks all anodes for
// the first BLANK_CYCLES cycles of every slot to suppress ghosting.
//
// Optional feature macro: DISPLAY_BRIGHTNESS_EN (adds bright_i, which trims
// the lit part of each slot).
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   wr_en_i        digit register write strobe
//   wr_addr_i[2:0] digit index written
//   wr_data_i[3:0] nibble written
//   digit_en_i[7:0] per-digit enable (0 keeps that anode off for its slot)
//   bright_i[2:0]  brightness level, sampled at slot start (macro only)
//   dig_bin_o[3:0] nibble of the current slot, to the decoder
//   an_o[7:0]      active-low anode drive, at most one bit low
//   cur_digit_o[2:0] index of the current slot
//   frame_tick_o   one-cycle pulse at the start of digit-0 slot after a wrap
module display_scan_ctrl #(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 16,
   parameter int unsigned NUM_DIGITS   = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       wr_en_i,
   input  logic [2:0] wr_addr_i,
   input  logic [3:0] wr_data_i,
   input  logic [7:0] digit_en_i,
`ifdef DISPLAY_BRIGHTNESS_EN
   input  logic [2:0] bright_i,
`endif
   output logic [3:0] dig_bin_o,
   output logic [7:0] an_o,
   output logic [2:0] cur_digit_o,
   output logic       frame_tick_o
);

   localparam int unsigned CW      = $clog2(REFRESH_DIV);
   localparam int unsigned LW      = CW + 4;
   localparam int unsigned SHOW_LEN = REFRESH_DIV - BLANK_CYCLES;

   typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_e;

   // cnt_q is the slot offset that the next clock edge will present
   logic [CW-1:0] cnt_q, cnt_d;
   state_e        state_q, state_d;
   logic [2:0]    cur_q, cur_d;
   logic          started_q, started_d;
   logic          en_q, en_d;
   logic [3:0]    dig_q, dig_d;
   logic [7:0]    an_q, an_d;
   logic          tick_q, tick_d;
   logic [3:0]    digit_q [NUM_DIGITS];

   logic [2:0]    next_idx;
   logic [CW-1:0] show_off;
   logic [LW-1:0] lit_len;

`ifdef DISPLAY_BRIGHTNESS_EN
   logic [2:0]    bright_q;
   logic [LW-1:0] lit_prod;

   // Brightness is reset-independent; latched at slot start
   always_ff @(posedge clk_i) begin
      if (cnt_q == '0) bright_q <= bright_i;
   end

   // Lit window = max(1, floor(S*(bright+1)/8))
   always_comb begin
      lit_prod = LW'(SHOW_LEN) * (LW'(bright_q) + LW'(1));
      lit_len  = lit_prod >> 3;
      if (lit_len == '0) lit_len = LW'(1);
   end
`else
   assign lit_len = LW'(SHOW_LEN);
`endif

   // Next-state and registered-output logic
   always_comb begin
      cnt_d     = (cnt_q == CW'(REFRESH_DIV - 1)) ? '0 : cnt_q + CW'(1);
      state_d   = state_q;
      cur_d     = cur_q;
      started_d = 1'b1;
      en_d      = en_q;
      dig_d     = dig_q;
      tick_d    = 1'b0;
      an_d      = 8'hFF;
      show_off  = cnt_q - CW'(BLANK_CYCLES);
      next_idx  = started_q ? cur_q + 3'd1 : 3'd0;

      // Slot start: advance digit and sample nibble/enable (pre-write contents)
      if (cnt_q == '0) begin
         cur_d  = next_idx;
         dig_d  = digit_q[next_idx];
         en_d   = digit_en_i[next_idx];
         tick_d = started_q && (cur_q == 3'd7);
      end

      case (state_q)
         BLANK:   if (cnt_q == CW'(BLANK_CYCLES)) state_d = SHOW;
         SHOW:    if (cnt_q == '0) state_d = BLANK;
         default: state_d = BLANK;
      endcase

      // en_q/cur_q are already valid here since SHOW never starts at offset 0
      if ((state_d == SHOW) && en_q && (LW'(show_off) < lit_len))
         an_d = ~(8'b1 << cur_q);
   end

   // State, output and digit register file
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         state_q   <= BLANK;
         cur_q     <= 3'd0;
         started_q <= 1'b0;
         en_q      <= 1'b0;
         dig_q     <= 4'd0;
         an_q      <= 8'hFF;
         tick_q    <= 1'b0;
         for (int i = 0; i < int'(NUM_DIGITS); i++) digit_q[i] <= 4'd0;
      end else begin
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         cur_q     <= cur_d;
         started_q <= started_d;
         en_q      <= en_d;
         dig_q     <= dig_d;
         an_q      <= an_d;
         tick_q    <= tick_d;
         if (wr_en_i) digit_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign dig_bin_o    = dig_q;
   assign an_o         = an_q;
   assign cur_digit_o  = cur_q;
   assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a driver applies stimulus at the
// falling edge and pushes the expected outputs computed from a slot/offset
// reference model; a monitor pops and compares after every rising edge.
module tb_display_scan_ctrl;

`ifdef DISPLAY_BRIGHTNESS_EN
   localparam int R = 34;
`else
   localparam int R = 8;
`endif
   localparam int B     = 2;
   localparam int FRAME = 8 * R;

   typedef struct packed {
      logic [7:0] an;
      logic [3:0] dig;
      logic [2:0] cur;
      logic       tick;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [3:0] wr_data = '0;
   logic [7:0] digit_en = 8'hFF;
   logic [2:0] bright = 3'd7;
   logic [3:0] dig_bin;
   logic [7:0] an;
   logic [2:0] cur_digit;
   logic       frame_tick;

   always #5 clk = ~clk;

   display_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .NUM_DIGITS(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .digit_en_i  (digit_en),
`ifdef DISPLAY_BRIGHTNESS_EN
      .bright_i    (bright),
`endif
      .dig_bin_o   (dig_bin),
      .an_o        (an),
      .cur_digit_o (cur_digit),
      .frame_tick_o(frame_tick)
   );

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model state: cycles since reset release and slot samples
   logic [3:0] m_dig [8];
   int         n = 0;
   logic [3:0] s_dig = '0;
   logic       s_en = 1'b0;
   int         s_br = 7;

   function automatic void check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, n, act, req);
      end
   endfunction

   // Expected outputs after the coming edge, from the slot arithmetic
   task automatic push_model();
      exp_t       e;
      int         slot, t, d, lit;
      logic [7:0] one;
      one = 8'd1;
      if (rst) begin
         e = '{an: 8'hFF, dig: 4'd0, cur: 3'd0, tick: 1'b0};
         n = 0;
         for (int i = 0; i < 8; i++) m_dig[i] = 4'd0;
      end else begin
         slot = n / R;
         t    = n % R;
         d    = slot % 8;
         if (t == 0) begin
            s_dig = m_dig[d];
            s_en  = digit_en[d];
            s_br  = int'(bright);
         end
         lit = ((R - B) * (s_br + 1)) / 8;
         if (lit < 1) lit = 1;
         e.an   = (t >= B && s_en && (t - B) < lit) ? ~(one << d) : 8'hFF;
         e.dig  = s_dig;
         e.cur  = 3'(d);
         e.tick = (t == 0) && (slot > 0) && (d == 0);
         if (wr_en) m_dig[wr_addr] = wr_data;
         n++;
      end
      q.push_back(e);
   endtask

   task automatic step(input logic r, input logic we, input int a, input int dat);
      @(negedge clk);
      rst     = r;
      wr_en   = we;
      wr_addr = 3'(a);
      wr_data = 4'(dat);
      push_model();
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) step(1'b0, 1'b0, 0, 0);
   endtask

   task automatic idle_until(input int phase);
      int guard;
      guard = 0;
      while ((n % FRAME) != phase && guard < 2 * FRAME) begin
         step(1'b0, 1'b0, 0, 0);
         guard++;
      end
      check("phase_reach", guard < 2 * FRAME, 1);
   endtask

   // Monitor: compare DUT outputs against the oldest expected entry
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("an", int'(an), int'(e.an));
            check("dig_bin", int'(dig_bin), int'(e.dig));
            check("cur_digit", int'(cur_digit), int'(e.cur));
            check("frame_tick", int'(frame_tick), int'(e.tick));
         end
      end
   end

   initial begin
      for (int i = 0; i < 8; i++) m_dig[i] = 4'd0;

      // Reset, then load digit i = i+3 during the first slot
      repeat (3) step(1'b1, 1'b0, 0, 0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i, i + 3);
      idle(2 * FRAME);

      // Tearing: rewrite digit 2 mid-slot
      idle_until(2 * R + 4);
      step(1'b0, 1'b1, 2, 4'hA);
      idle(FRAME);

      // Disabled digit 3 for one frame
      idle_until(0);
      digit_en = 8'b1111_0111;
      idle(FRAME);
      digit_en = 8'hFF;
      idle(FRAME);

`ifdef DISPLAY_BRIGHTNESS_EN
      foreach (bright[i]) begin end
      bright = 3'd1; idle(FRAME);
      bright = 3'd0; idle(FRAME);
      bright = 3'd7; idle(FRAME);
`endif

      // Randomized writes, enables and brightness
      repeat (4 * FRAME) begin
         if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
`ifdef DISPLAY_BRIGHTNESS_EN
         if ($urandom_range(0, 7) == 0) bright = 3'($urandom_range(0, 7));
`endif
         if ($urandom_range(0, 2) == 0)
            step(1'b0, 1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
         else
            step(1'b0, 1'b0, 0, 0);
      end
      digit_en = 8'hFF;
      bright   = 3'd7;

      // Mid-slot reset (with a write that must be ignored), then scan zeros
      idle_until(6 * R + 5);
      step(1'b1, 1'b1, 3, 9);
      idle(2 * FRAME);

      @(posedge clk);
      #2;
      check("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
